// File: rtl/rename_regfile_pkg.sv
// rename_regfile_pkg: shared widths and the ROB tag type for the rename register file, ROB, RS and decoder.
package rename_regfile_pkg;
  localparam int RF_XLEN      = 32;
  localparam int RF_NREG      = 32;
  localparam int RF_AW        = $clog2(RF_NREG);
  localparam int RF_ROB_DEPTH = 16;
  localparam int RF_TW        = $clog2(RF_ROB_DEPTH);
  typedef logic [RF_TW-1:0] rob_tag_t;
endpackage

// File: rtl/rename_regfile_rf_read_port.sv
// rf_read_port: one combinational register lookup; with RENAME_BYPASS_EN a matching commit is forwarded.
module rf_read_port
  import rename_regfile_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int AW   = RF_AW,
  parameter int TW   = RF_TW
) (
  input  logic [AW-1:0]              rd_addr,
  input  logic [NREG-1:0][XLEN-1:0]  reg_val,
  input  logic [NREG-1:0]            reg_busy,
  input  logic [NREG-1:0][TW-1:0]    reg_tag,
`ifdef RENAME_BYPASS_EN
  input  logic                       cmt_fire,
  input  logic [AW-1:0]              cmt_rd,
  input  logic [TW-1:0]              cmt_tag,
  input  logic [XLEN-1:0]            cmt_val,
`endif
  output logic [XLEN-1:0]            rd_val,
  output logic                       rd_busy,
  output logic [TW-1:0]              rd_tag
);
`ifdef RENAME_BYPASS_EN
  logic w_hit;
  assign w_hit   = cmt_fire && rd_addr != '0 && cmt_rd == rd_addr &&
                   reg_busy[rd_addr] && reg_tag[rd_addr] == cmt_tag;
  assign rd_val  = w_hit ? cmt_val : reg_val[rd_addr];
  assign rd_busy = !w_hit && reg_busy[rd_addr];
`else
  assign rd_val  = reg_val[rd_addr];
  assign rd_busy = reg_busy[rd_addr];
`endif
  assign rd_tag  = reg_tag[rd_addr];
endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: architectural values plus busy/tag rename state, NRD combinational read ports.
// Define RENAME_BYPASS_EN to forward a same-cycle commit to matching readers.
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int XLEN      = RF_XLEN,
  parameter int NREG      = RF_NREG,
  parameter int ROB_DEPTH = RF_ROB_DEPTH,
  parameter int NRD       = 2,
  localparam int AW       = $clog2(NREG),
  localparam int TW       = $clog2(ROB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_val,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*TW-1:0]    rd_tag,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_rd,
  input  logic [TW-1:0]        iss_tag,
  input  logic                 cmt_en,
  input  logic [AW-1:0]        cmt_rd,
  input  logic [TW-1:0]        cmt_tag,
  input  logic [XLEN-1:0]      cmt_val
);
  logic [NREG-1:0][XLEN-1:0] r_val;
  logic [NREG-1:0]           r_busy;
  logic [NREG-1:0][TW-1:0]   r_tag;
  logic                      w_iss;
  logic                      w_cmt;
  logic                      w_clr;
  assign w_iss = iss_en && iss_rd != '0;
  assign w_cmt = cmt_en && cmt_rd != '0;
  // a same-cycle issue to the committing register keeps it renamed
  assign w_clr = w_cmt && r_tag[cmt_rd] == cmt_tag && !(w_iss && iss_rd == cmt_rd);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val  <= '0;
      r_busy <= '0;
      r_tag  <= '0;
    end else if (rdy) begin
      if (w_cmt) r_val[cmt_rd] <= cmt_val;
      if (rollback) begin
        r_busy <= '0;
        r_tag  <= '0;
      end else begin
        if (w_clr) r_busy[cmt_rd] <= 1'b0;
        if (w_iss) begin
          r_busy[iss_rd] <= 1'b1;
          r_tag[iss_rd]  <= iss_tag;
        end
      end
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rf_read_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .TW(TW)) u_port (
      .rd_addr  (rd_addr[k*AW +: AW]),
      .reg_val  (r_val),
      .reg_busy (r_busy),
      .reg_tag  (r_tag),
`ifdef RENAME_BYPASS_EN
      .cmt_fire (rdy && cmt_en),
      .cmt_rd   (cmt_rd),
      .cmt_tag  (cmt_tag),
      .cmt_val  (cmt_val),
`endif
      .rd_val   (rd_val[k*XLEN +: XLEN]),
      .rd_busy  (rd_busy[k]),
      .rd_tag   (rd_tag[k*TW +: TW])
    );
  end
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed rename/commit/rollback vectors; expected reads are queued and checked by a monitor.
module tb_rename_regfile;
  import rename_regfile_pkg::*;
`ifdef RENAME_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, rdy, rollback, iss_en, cmt_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_val;
  logic [1:0]  rd_busy;
  logic [7:0]  rd_tag;
  logic [4:0]  iss_rd, cmt_rd;
  rob_tag_t    iss_tag, cmt_tag;
  logic [31:0] cmt_val;
  typedef struct {
    int          port;
    int          addr;
    logic [31:0] val;
    logic        busy;
    int          tag;
  } exp_t;
  exp_t  q[$];
  string qn[$];
  int    n_pass = 0;
  int    n_total = 0;

  rename_regfile dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .rd_addr(rd_addr), .rd_val(rd_val), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_tag(iss_tag),
    .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_val(cmt_val)
  );

  always #5 clk = ~clk;

  // tag of -1 means the tag is don't-care (register not busy, tag not defined)
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      string       n;
      logic [31:0] v;
      logic [3:0]  t;
      e = q.pop_front();
      n = qn.pop_front();
      v = rd_val[e.port*32 +: 32];
      t = rd_tag[e.port*4 +: 4];
      n_total++;
      if (v === e.val && rd_busy[e.port] === e.busy && (e.tag < 0 || t === 4'(e.tag)))
        n_pass++;
      else
        $display("FAIL %s: x%0d port%0d got val=%h busy=%b tag=%0d, want val=%h busy=%b tag=%0d",
                 n, e.addr, e.port, v, rd_busy[e.port], t, e.val, e.busy, e.tag);
    end
  end

  task automatic ex(input int p, input int a, input logic [31:0] v, input logic b, input int t,
                    input string n);
    rd_addr[p*5 +: 5] = 5'(a);
    q.push_back('{p, a, v, b, t});
    qn.push_back(n);
  endtask

  task automatic iss(input int r, input int t);
    iss_en = 1'b1; iss_rd = 5'(r); iss_tag = 4'(t);
  endtask

  task automatic cmt(input int r, input int t, input logic [31:0] v);
    cmt_en = 1'b1; cmt_rd = 5'(r); cmt_tag = 4'(t); cmt_val = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    iss_en = 1'b0; cmt_en = 1'b0; rollback = 1'b0; rdy = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b1; rd_addr = '0;
    iss(5, 3); cmt(6, 1, 32'hAB);
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ex(0, a, 0, 0, 0, "reset_p0");
      ex(1, a, 0, 0, 0, "reset_p1");
      tick();
    end
    iss(5, 3); tick();
    ex(0, 5, 0, 1, 3, "iss_x5"); ex(1, 0, 0, 0, 0, "x0_idle"); tick();
    cmt(5, 3, 32'hDEADBEEF);
    ex(1, 5, BYP ? 32'hDEADBEEF : 32'h0, !BYP, 3, "cmt_x5_same_cycle");
    ex(0, 4, 0, 0, 0, "x4_no_leak");
    tick();
    ex(0, 5, 32'hDEADBEEF, 0, -1, "cmt_x5_after"); tick();
    iss(7, 2); tick();
    iss(7, 9); ex(0, 7, 0, 1, 2, "x7_tag2"); tick();
    cmt(7, 2, 32'h11); ex(0, 7, 0, 1, 9, "x7_tag9_stale_cmt"); tick();
    ex(0, 7, 32'h11, 1, 9, "x7_after_stale_cmt"); tick();
    iss(3, 4); tick();
    iss(3, 4); cmt(3, 4, 32'h22);
    ex(0, 3, BYP ? 32'h22 : 32'h0, !BYP, 4, "x3_iss_cmt_same_cycle");
    tick();
    ex(0, 3, 32'h22, 1, 4, "x3_iss_cmt_after"); tick();
    for (int r = 1; r <= 4; r++) begin
      iss(r, r); tick();
    end
    rollback = 1'b1; cmt(2, 2, 32'h55); iss(6, 5);
    ex(0, 2, BYP ? 32'h55 : 32'h0, !BYP, 2, "rb_x2_same_cycle");
    ex(1, 6, 0, 0, 0, "rb_x6_same_cycle");
    tick();
    ex(0, 1, 0, 0, 0, "rb_x1"); ex(1, 2, 32'h55, 0, 0, "rb_x2"); tick();
    ex(0, 3, 32'h22, 0, 0, "rb_x3"); ex(1, 4, 0, 0, 0, "rb_x4"); tick();
    ex(0, 6, 0, 0, 0, "rb_x6_dropped"); ex(1, 7, 32'h11, 0, 0, "rb_x7"); tick();
    ex(0, 5, 32'hDEADBEEF, 0, 0, "rb_x5"); tick();
    iss(9, 6); tick();
    cmt(9, 6, 32'h77);
    ex(1, 9, BYP ? 32'h77 : 32'h0, !BYP, 6, "byp_x9");
    ex(0, 8, 0, 0, 0, "byp_x8_no_leak");
    tick();
    ex(1, 9, 32'h77, 0, -1, "x9_after"); tick();
    iss(0, 5); cmt(0, 5, 32'hFF); tick();
    ex(0, 0, 0, 0, 0, "x0_p0"); ex(1, 0, 0, 0, 0, "x0_p1"); tick();
    iss(11, 7); tick();
    rdy = 1'b0; rollback = 1'b1; iss(10, 1); cmt(11, 7, 32'h99);
    ex(0, 11, 0, 1, 7, "rdy_low_read");
    tick();
    ex(0, 11, 0, 1, 7, "rdy_low_hold"); ex(1, 10, 0, 0, 0, "rdy_low_no_iss"); tick();
    rst = 1'b1; iss(12, 3); cmt(5, 0, 32'h1234);
    ex(0, 11, 0, 1, 7, "pre_rst_x11");
    tick();
    rst = 1'b0;
    ex(0, 11, 0, 0, 0, "rst_x11"); ex(1, 5, 0, 0, 0, "rst_x5"); tick();
    ex(0, 12, 0, 0, 0, "rst_x12"); ex(1, 9, 0, 0, 0, "rst_x9"); tick();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 Parameter XLEN, 32, data width of each architectural register.
REQ-002 Parameter NREG, 32, architectural register count; address width AW = clog2(NREG).
REQ-003 Parameter ROB_DEPTH, 16, reorder-buffer entries; tag width TW = clog2(ROB_DEPTH).
REQ-004 Parameter NRD, 2, number of independent read ports.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rdy  input  1  global enable; low freezes all state.
REQ-008 rollback  input  1  flush all rename state (mispredict).
REQ-009 rd_addr  input  NRD*AW  read addresses, port k in slice k.
REQ-010 rd_val  output  NRD*XLEN  committed value per port.
REQ-011 rd_busy  output  NRD  register awaits an in-flight producer, per port.
REQ-012 rd_tag  output  NRD*TW  ROB tag of pending producer, per port; valid only when busy.
REQ-013 iss_en / iss_rd / iss_tag  input  1 / AW / TW  issue: rename iss_rd to ROB entry iss_tag.
REQ-014 cmt_en / cmt_rd / cmt_tag / cmt_val  input  1 / AW / TW / XLEN  commit from ROB head.

Function
REQ-015 Read ports SHALL be combinational: rd_val/rd_busy/rd_tag reflect current state in the same cycle, all ports independent, including same address on several ports.
REQ-016 Register 0 SHALL read value 0, busy 0, tag 0 always; issue and commit to register 0 SHALL be ignored.
REQ-017 Issue (iss_en, rdy) SHALL set busy[iss_rd]=1 and tag[iss_rd]=iss_tag at the next edge, overwriting any older tag.
REQ-018 Commit (cmt_en, rdy) SHALL write cmt_val into value[cmt_rd] at the next edge unconditionally.
REQ-019 Commit SHALL clear busy[cmt_rd] only if tag[cmt_rd]==cmt_tag and no issue targets cmt_rd in the same cycle.
REQ-020 Issue and commit to the same register in one cycle: value written, busy stays 1, tag becomes iss_tag.
REQ-021 Rollback (rdy high) SHALL clear every busy bit and tag to 0 at the next edge; values retained; same-cycle commit value write still applied; same-cycle issue discarded.
REQ-022 rdy low SHALL suppress issue, commit and rollback; reads remain valid.
REQ-023 Write latency one cycle; a read in the commit cycle sees pre-commit state unless REQ-027 applies.

Reset
REQ-024 rst SHALL set all values 0, busy 0, tags 0 at the next edge, overriding rdy, rollback, issue and commit.
REQ-025 After reset every read port SHALL output rd_val=0, rd_busy=0, rd_tag=0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight renames; no partial commit survives.

Configuration
REQ-027 With RENAME_BYPASS_EN defined, a port reading a register that is busy with tag==cmt_tag while cmt_en&&rdy SHALL return rd_val=cmt_val, rd_busy=0 in that cycle; never for register 0.
REQ-028 Without RENAME_BYPASS_EN, reads SHALL return stored state only; no comparator logic synthesised.

Structure
REQ-029 Shared package SHALL hold XLEN, register address width, ROB tag width and the rob_tag typedef used by ROB, RS and decoder.
REQ-030 One sub-module rf_read_port (lookup plus optional bypass mux) SHALL be instantiated NRD times.

Verification
REQ-031 Reset, then read x1..x31 on both ports -> val 0, busy 0, tag 0.
REQ-032 Issue x5 tag 3; next cycle read x5 -> busy 1, tag 3; commit x5 tag 3 val 0xDEADBEEF -> next cycle val 0xDEADBEEF, busy 0.
REQ-033 Issue x7 tag 2, issue x7 tag 9, commit x7 tag 2 val 0x11 -> val 0x11, busy 1, tag 9.
REQ-034 Issue x3 tag 4 and commit x3 tag 4 val 0x22 same cycle (x3 previously tag 4) -> val 0x22, busy 1, tag 4.
REQ-035 Issue x1..x4, assert rollback with commit x2 val 0x55 -> all busy 0, x2 val 0x55, others unchanged.
REQ-036 RENAME_BYPASS_EN: x9 busy tag 6, commit x9 tag 6 val 0x77 while port 1 reads x9 -> same cycle val 0x77, busy 0; without macro -> old value, busy 1.
